// File: rtl/hit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hit_pkg
//  Description : Shared definitions for the hit arbitration block: FSM state
//                encoding, default parameter values and a width helper.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Contents
//    DEF_NUM_SRC / DEF_IFRAMES / DEF_BLINK_DIV : default parameter values
//    state_e                                   : arbiter FSM state encoding
//    width_of(n)                               : clog2(n), never below 1 bit
// ============================================================================
package hit_pkg;

  localparam int DEF_NUM_SRC   = 4;   // number of hit sources
  localparam int DEF_IFRAMES   = 60;  // invulnerability length in frames
  localparam int DEF_BLINK_DIV = 8;   // frames per blink half-period

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_STRIKE   = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

  // A zero-width vector is illegal, so degenerate sizes still get one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : hit_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Returns the first set
//                request found when searching upward from ptr_i, wrapping
//                from NUM_SRC-1 back to 0.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    req_i   in   NUM_SRC  request vector
//    ptr_i   in   IDW      index where the search starts
//    grant_o out  IDW      granted index (0 when nothing is requested)
//    valid_o out  1        at least one request was present
// ============================================================================
module rr_arbiter
  import hit_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC
) (
  input  logic [NUM_SRC-1:0]            req_i,
  input  logic [width_of(NUM_SRC)-1:0]  ptr_i,
  output logic [width_of(NUM_SRC)-1:0]  grant_o,
  output logic                          valid_o
);

  localparam int IDW = width_of(NUM_SRC);

  logic [IDW-1:0] idx;
  int             sum;

  // Scan offsets from farthest to nearest; the last hit written wins, which
  // leaves the request closest to the pointer (in wrap order) as the grant.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    sum     = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      sum = int'(ptr_i) + k;
      if (sum >= NUM_SRC) begin
        sum = sum - NUM_SRC;
      end
      idx = IDW'(sum);
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/hit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hit_arbiter
//  Description : Arbitrates collision flags from several hit sources into
//                single damage pulses for the HP block, then holds the player
//                invulnerable for IFRAMES frame ticks while a blink enable
//                drives the sprite. Hits arriving during the window are lost.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1        system clock
//    rst         in   1        synchronous active-high reset
//    game_on     in   1        game-active level (0 forces IDLE)
//    game_over   in   1        one-cycle end-of-game pulse (forces IDLE)
//    vblnk_in    in   1        vertical blank; each rising edge = one frame
//    hit_src     in   NUM_SRC  level collision flags, one per source
//    player_hit  out  1        one-cycle damage pulse
//    hit_id      out  IDW      index of the last granted source
//    invuln      out  1        high in STRIKE and COOLDOWN
//    blink       out  1        sprite blink enable during COOLDOWN
//    hit_count   out  3        hits granted this game, saturating at 7
// ============================================================================
module hit_arbiter
  import hit_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int IFRAMES   = DEF_IFRAMES,
  parameter int BLINK_DIV = DEF_BLINK_DIV
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          game_on,
  input  logic                          game_over,
  input  logic                          vblnk_in,
  input  logic [NUM_SRC-1:0]            hit_src,
  output logic                          player_hit,
  output logic [width_of(NUM_SRC)-1:0]  hit_id,
  output logic                          invuln,
  output logic                          blink,
  output logic [2:0]                    hit_count
);

  localparam int IDW = width_of(NUM_SRC);
  localparam int FCW = width_of(IFRAMES + 1);
  localparam int BDW = width_of(BLINK_DIV);

  localparam logic [FCW-1:0] FRAME_LOAD = FCW'(IFRAMES);
  localparam logic [BDW-1:0] BLINK_LAST = BDW'(BLINK_DIV - 1);
  localparam logic [IDW-1:0] LAST_SRC   = IDW'(NUM_SRC - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e             state_q,       state_d;
  logic [NUM_SRC-1:0] pending_q,     pending_d;
  logic [IDW-1:0]     last_grant_q,  last_grant_d;
  logic [FCW-1:0]     frame_cnt_q,   frame_cnt_d;
  logic [BDW-1:0]     blink_div_q,   blink_div_d;
  logic               blink_phase_q, blink_phase_d;
  logic               player_hit_q,  player_hit_d;
  logic               invuln_q,      invuln_d;
  logic               blink_q,       blink_d;
  logic [2:0]         hit_count_q,   hit_count_d;

  // Previous-sample registers for edge detection.
  logic               vblnk_prev_q;
  logic [NUM_SRC-1:0] hit_prev_q;

  // --------------------------------------------------------------------------
  // Edge detection and round-robin pick
  // --------------------------------------------------------------------------
  logic               frame_tick;
  logic [NUM_SRC-1:0] src_rise;
  logic               abort;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     rr_grant;
  logic               rr_valid;
  logic [NUM_SRC-1:0] grant_mask;

  assign frame_tick = vblnk_in & ~vblnk_prev_q;
  assign src_rise   = hit_src & ~hit_prev_q;
  assign abort      = ~game_on | game_over;

  // Search starts one past the previous winner so a source that keeps
  // colliding cannot starve the others.
  assign rr_ptr     = (last_grant_q == LAST_SRC) ? '0 : last_grant_q + IDW'(1);
  assign grant_mask = NUM_SRC'(1) << rr_grant;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_arbiter (
    .req_i   (pending_q),
    .ptr_i   (rr_ptr),
    .grant_o (rr_grant),
    .valid_o (rr_valid)
  );

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    last_grant_d  = last_grant_q;
    frame_cnt_d   = frame_cnt_q;
    blink_div_d   = blink_div_q;
    blink_phase_d = blink_phase_q;
    player_hit_d  = 1'b0;
    hit_count_d   = hit_count_q;

    if (abort) begin
      // Highest priority: drop everything, including a strike in flight.
      state_d   = ST_IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pending_d     = '0;
          hit_count_d   = '0;
          blink_phase_d = 1'b0;
          blink_div_d   = '0;
          state_d       = ST_ARMED;
        end

        ST_ARMED: begin
          // New edges are queued even on a grant cycle; an edge on the
          // source being granted merges into that grant.
          if (rr_valid) begin
            pending_d    = (pending_q | src_rise) & ~grant_mask;
            last_grant_d = rr_grant;
            state_d      = ST_STRIKE;
          end else begin
            pending_d    = pending_q | src_rise;
          end
        end

        ST_STRIKE: begin
          player_hit_d  = 1'b1;
          hit_count_d   = (hit_count_q == 3'd7) ? 3'd7 : hit_count_q + 3'd1;
          frame_cnt_d   = FRAME_LOAD;
          pending_d     = '0;
          blink_phase_d = 1'b1;
          blink_div_d   = '0;
          state_d       = ST_COOLDOWN;
        end

        ST_COOLDOWN: begin
          pending_d = '0;
          if (frame_cnt_q == '0) begin
            state_d = ST_ARMED;
          end else if (frame_tick) begin
            frame_cnt_d = frame_cnt_q - FCW'(1);
            if (blink_div_q == BLINK_LAST) begin
              blink_div_d   = '0;
              blink_phase_d = ~blink_phase_q;
            end else begin
              blink_div_d   = blink_div_q + BDW'(1);
            end
          end
        end

        default: begin
          state_d   = ST_IDLE;
          pending_d = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register rather than lagging it by a cycle.
    invuln_d = (state_d == ST_STRIKE) || (state_d == ST_COOLDOWN);
    blink_d  = (state_d == ST_COOLDOWN) && blink_phase_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      last_grant_q  <= '0;
      frame_cnt_q   <= '0;
      blink_div_q   <= '0;
      blink_phase_q <= 1'b0;
      player_hit_q  <= 1'b0;
      invuln_q      <= 1'b0;
      blink_q       <= 1'b0;
      hit_count_q   <= '0;
      vblnk_prev_q  <= 1'b0;
      hit_prev_q    <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      last_grant_q  <= last_grant_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_div_q   <= blink_div_d;
      blink_phase_q <= blink_phase_d;
      player_hit_q  <= player_hit_d;
      invuln_q      <= invuln_d;
      blink_q       <= blink_d;
      hit_count_q   <= hit_count_d;
      vblnk_prev_q  <= vblnk_in;
      hit_prev_q    <= hit_src;
    end
  end

  assign player_hit = player_hit_q;
  assign hit_id     = last_grant_q;
  assign invuln     = invuln_q;
  assign blink      = blink_q;
  assign hit_count  = hit_count_q;

endmodule : hit_arbiter
`default_nettype wire

// File: tb/tb_hit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hit_arbiter
//  Description : Directed self-checking bench for hit_arbiter. Stimulus
//                pushes the expected (hit_id, hit_count) of every damage
//                pulse into a queue; an independent monitor pops and compares
//                on each player_hit. Level checks cover reset, invulnerability
//                length, blink pattern and abort behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hit_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_on;
  logic       game_over;
  logic       vblnk_in;
  logic [3:0] hit_src;
  logic       player_hit;
  logic [1:0] hit_id;
  logic       invuln;
  logic       blink;
  logic [2:0] hit_count;

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hit_arbiter #(
    .NUM_SRC   (4),
    .IFRAMES   (60),
    .BLINK_DIV (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .game_on    (game_on),
    .game_over  (game_over),
    .vblnk_in   (vblnk_in),
    .hit_src    (hit_src),
    .player_hit (player_hit),
    .hit_id     (hit_id),
    .invuln     (invuln),
    .blink      (blink),
    .hit_count  (hit_count)
  );

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_hit(input int id, input int cnt);
    exp_q.push_back(exp_t'{id: 2'(id), cnt: 3'(cnt)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame = three clocks with vblnk high for the first.
  task automatic frames(input int n);
    repeat (n) begin
      vblnk_in = 1'b1;
      step();
      vblnk_in = 1'b0;
      step();
      step();
    end
  endtask

  // Scoreboard monitor: every damage pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && player_hit) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_hit: got pulse hit_id=%0d hit_count=%0d, expected no pulse",
                 hit_id, hit_count);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_hit_id", int'(hit_id), int'(mon_e.id));
        check("pulse_hit_count", int'(hit_count), int'(mon_e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; game_on = 1'b0; game_over = 1'b0; vblnk_in = 1'b0; hit_src = '0;
    repeat (3) step();

    // Reset state
    check("rst_player_hit", player_hit, 0);
    check("rst_hit_id", hit_id, 0);
    check("rst_invuln", invuln, 0);
    check("rst_blink", blink, 0);
    check("rst_hit_count", hit_count, 0);
    rst = 1'b0;

    // Single held source: one pulse, 60-frame window, blink pattern
    game_on = 1'b1;
    step(); step();
    check("armed_invuln", invuln, 0);
    expect_hit(2, 1);
    hit_src[2] = 1'b1;
    step(); step(); step();
    check("cd_entry_invuln", invuln, 1);
    check("cd_entry_blink", blink, 1);
    for (int k = 1; k <= 59; k++) begin
      frames(1);
      check("cd_invuln", invuln, 1);
      check("cd_blink", blink, ((k / 8) % 2 == 0) ? 1 : 0);
    end
    frames(1);
    check("cd_end_invuln", invuln, 0);
    check("cd_end_blink", blink, 0);
    frames(140);
    check("held_hit_count", hit_count, 1);
    check("held_hit_id", hit_id, 2);
    hit_src = '0;
    step();

    // Simultaneous edges with last_grant=0: source 3 wins, source 0 dropped
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst2_hit_id", hit_id, 0);
    step(); step();
    expect_hit(3, 1);
    hit_src = 4'b1001;
    step(); step(); step();
    check("rr_hit_id", hit_id, 3);
    frames(61);
    repeat (4) step();
    check("rr_hit_count", hit_count, 1);
    check("rr_invuln_after", invuln, 0);
    hit_src = '0;
    step();

    // Repeated hits from source 1 and saturation at 7
    game_on = 1'b0;
    step(); step();
    check("off_invuln", invuln, 0);
    game_on = 1'b1;
    step(); step();
    check("newgame_hit_count", hit_count, 0);
    for (int i = 1; i <= 8; i++) begin
      expect_hit(1, (i > 7) ? 7 : i);
      hit_src[1] = 1'b1;
      step(); step(); step();
      hit_src[1] = 1'b0;
      frames(62);
      if (i == 3) check("three_hits_count", hit_count, 3);
    end
    check("sat_hit_count", hit_count, 7);

    // Edge during cooldown is discarded and does not linger
    expect_hit(0, 7);
    hit_src[0] = 1'b1;
    step(); step(); step();
    hit_src[0] = 1'b0;
    frames(30);
    hit_src[1] = 1'b1;
    frames(31);
    repeat (5) step();
    check("late_edge_invuln", invuln, 0);
    check("late_edge_hit_id", hit_id, 0);
    hit_src = '0;
    step();

    // game_on falls during STRIKE: no pulse, IDLE, count cleared
    hit_src[2] = 1'b1;
    step(); step();
    check("strike_invuln", invuln, 1);
    game_on = 1'b0;
    step();
    check("abort_player_hit", player_hit, 0);
    check("abort_invuln", invuln, 0);
    hit_src = '0;
    game_on = 1'b1;
    step(); step();
    check("reentry_hit_count", hit_count, 0);

    // game_over pulse during STRIKE
    hit_src[3] = 1'b1;
    step(); step();
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check("gameover_player_hit", player_hit, 0);
    check("gameover_invuln", invuln, 0);
    hit_src = '0;
    step(); step();

    // rst at frame 10 of cooldown
    expect_hit(2, 1);
    hit_src[2] = 1'b1;
    step(); step(); step();
    frames(10);
    check("cd10_invuln", invuln, 1);
    rst = 1'b1;
    step();
    check("rstcd_player_hit", player_hit, 0);
    check("rstcd_invuln", invuln, 0);
    check("rstcd_blink", blink, 0);
    check("rstcd_hit_count", hit_count, 0);
    rst = 1'b0;
    hit_src = '0;
    step(); step();
    check("rstcd_reentry_count", hit_count, 0);
    check("rstcd_reentry_invuln", invuln, 0);
    repeat (4) step();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hit_arbiter
`default_nettype wire
